core_regfile_mp: RTL

- Parametrised multi-port integer register file for the next-generation core; replaces the fixed 2R1W 32x32 file.
- Provides NRD combinational read ports and two write ports: W0 for ALU/early writeback, W1 for load/late writeback.
- Adds a per-register busy scoreboard for issue hazard checks.
- Clears the array with a sequential init walk after reset instead of an asynchronous array reset, so the storage can map to distributed RAM.

---
 rtl/core_regfile_mp.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/core_regfile_mp.sv
// ----------------------------------------------------------------------------
// core_regfile_mp
//   Parametrised multi-port integer register file with a per-register busy
//   scoreboard. Entry 0 is hard-wired to zero. After reset a sequential walk
//   clears entries 1..NREG-1, so the storage needs no reset and can map to
//   distributed RAM. Traffic is accepted only once init_done is high.
//
//   Optional build macro: CORE_RF_BYPASS_EN
//     defined   : write-first forwarding of same-cycle writes on every read
//                 port, with matching suppression of rd_busy.
//     undefined : reads return the stored array value only.
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset (restarts the init walk)
//   init_done  out  high once the init walk has completed
//   rd_addr    in   NRD*AW   read addresses, port k = [k*AW +: AW]
//   rd_data    out  NRD*XLEN read data, port k = [k*XLEN +: XLEN]
//   rd_busy    out  NRD      scoreboard busy bit of each read address
//   we0/wa0/wd0 in  write port 0 (ALU / early writeback)
//   we1/wa1/wd1 in  write port 1 (load / late writeback, wins on collision)
//   rsv_en     in   mark rsv_addr busy
//   rsv_addr   in   register to reserve
//   sb_clr     in   clear all busy bits (overrides reserve and write clears)
// ----------------------------------------------------------------------------
module core_regfile_mp #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 init_done,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [XLEN-1:0]      wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 sb_clr
);

    localparam int NREG = 1 << AW;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        walk_q, walk_d;
    logic [NREG-1:0]      busy_q, busy_d;
    logic [XLEN-1:0]      mem_q [NREG];
    logic                 run;
    logic                 wr0_ok, wr1_ok;
    logic [AW-1:0]        ra;

    // ------------------------------------------------------------------
    // Init FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_INIT;
            walk_q  <= AW'(1);
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
        end
    end

    // Init FSM: next state
    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        if (state_q == S_INIT) begin
            walk_d = walk_q + AW'(1);
            if (walk_q == AW'(NREG - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // Init FSM: outputs
    always_comb begin
        run       = (state_q == S_RUN);
        init_done = run;
    end

    // ------------------------------------------------------------------
    // Storage: no reset, cleared by the walk. W0 is dropped on an address
    // collision with W1 so only one write lands per entry per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        wr1_ok = run && we1 && (wa1 != '0);
        wr0_ok = run && we0 && (wa0 != '0) && !(we1 && (wa1 == wa0));
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[walk_q] <= '0;
        end else begin
            if (wr0_ok) mem_q[wa0] <= wd0;
            if (wr1_ok) mem_q[wa1] <= wd1;
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: flush > reserve set > write clear
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (sb_clr) begin
                busy_d = '0;
            end else begin
                if (we0)    busy_d[wa0]      = 1'b0;
                if (we1)    busy_d[wa1]      = 1'b0;
                if (rsv_en) busy_d[rsv_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: combinational, zero while the walk is running
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            if (run && (ra != '0)) begin
                rd_data[k*XLEN +: XLEN] = mem_q[ra];
                rd_busy[k]              = busy_q[ra];
`ifdef CORE_RF_BYPASS_EN
                if (we1 && (wa1 == ra)) begin
                    rd_data[k*XLEN +: XLEN] = wd1;
                end else if (we0 && (wa0 == ra)) begin
                    rd_data[k*XLEN +: XLEN] = wd0;
                end
                // A same-cycle write retires the producer unless a new
                // reservation to the same register lands in that cycle.
                if (((we1 && (wa1 == ra)) || (we0 && (wa0 == ra))) &&
                    !(rsv_en && (rsv_addr == ra))) begin
                    rd_busy[k] = 1'b0;
                end
`endif
            end
        end
    end

endmodule
